edge_window_controller: RTL and testbench

//  Upstream/downstream controller for the 5x5 edge detection core.
//  - Input side: gathers a 25-pixel byte stream (row-major) into a 5x5 window, drives it on
//    o_m1..o_m25 and pulses o_gradient_start.
//  - Output side: waits for the core's o_gradient_ready, captures the nine 8-bit sums and

---
 rtl/edge_window_controller.sv | 195 +++++++++++++++++++
 tb/tb_edge_window_controller.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_window_controller.sv
// rtl/edge_window_controller.sv - 5x5 window loader and result serialiser for the edge core
// Optional build macro EDGE_THRESH_EN binarises captured sums against THRESHOLD.
module edge_window_controller #(
    parameter int TIMEOUT   = 256,
    parameter int THRESHOLD = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pix_valid,
    input  logic [7:0] i_pix_data,
    output logic       o_pix_ready,
    output logic [7:0] o_m1,
    output logic [7:0] o_m2,
    output logic [7:0] o_m3,
    output logic [7:0] o_m4,
    output logic [7:0] o_m5,
    output logic [7:0] o_m6,
    output logic [7:0] o_m7,
    output logic [7:0] o_m8,
    output logic [7:0] o_m9,
    output logic [7:0] o_m10,
    output logic [7:0] o_m11,
    output logic [7:0] o_m12,
    output logic [7:0] o_m13,
    output logic [7:0] o_m14,
    output logic [7:0] o_m15,
    output logic [7:0] o_m16,
    output logic [7:0] o_m17,
    output logic [7:0] o_m18,
    output logic [7:0] o_m19,
    output logic [7:0] o_m20,
    output logic [7:0] o_m21,
    output logic [7:0] o_m22,
    output logic [7:0] o_m23,
    output logic [7:0] o_m24,
    output logic [7:0] o_m25,
    output logic       o_gradient_start,
    input  logic       i_gradient_ready,
    input  logic [7:0] i_sum_1,
    input  logic [7:0] i_sum_2,
    input  logic [7:0] i_sum_3,
    input  logic [7:0] i_sum_4,
    input  logic [7:0] i_sum_5,
    input  logic [7:0] i_sum_6,
    input  logic [7:0] i_sum_7,
    input  logic [7:0] i_sum_8,
    input  logic [7:0] i_sum_9,
    output logic       o_res_valid,
    output logic [7:0] o_res_data,
    output logic       o_res_last,
    input  logic       i_res_ready,
    output logic       o_timeout
);

    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    if (TIMEOUT < 2 || THRESHOLD < 0 || THRESHOLD > 256) begin : g_bad_param
        $error("edge_window_controller: TIMEOUT must be >= 2 and THRESHOLD within 0..256");
    end

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_SEND
    } state_t;

    state_t            state;
    logic [4:0]        pix_cnt;
    logic [3:0]        res_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [7:0]        window  [25];
    logic [7:0]        sum_buf [9];
    logic [7:0]        sum_in  [9];

    function automatic logic [7:0] cond_sum(input logic [7:0] s);
`ifdef EDGE_THRESH_EN
        return (int'(s) >= THRESHOLD) ? 8'hFF : 8'h00;
`else
        return s;
`endif
    endfunction

    assign sum_in[0] = cond_sum(i_sum_1);
    assign sum_in[1] = cond_sum(i_sum_2);
    assign sum_in[2] = cond_sum(i_sum_3);
    assign sum_in[3] = cond_sum(i_sum_4);
    assign sum_in[4] = cond_sum(i_sum_5);
    assign sum_in[5] = cond_sum(i_sum_6);
    assign sum_in[6] = cond_sum(i_sum_7);
    assign sum_in[7] = cond_sum(i_sum_8);
    assign sum_in[8] = cond_sum(i_sum_9);

    assign o_m1  = window[0];
    assign o_m2  = window[1];
    assign o_m3  = window[2];
    assign o_m4  = window[3];
    assign o_m5  = window[4];
    assign o_m6  = window[5];
    assign o_m7  = window[6];
    assign o_m8  = window[7];
    assign o_m9  = window[8];
    assign o_m10 = window[9];
    assign o_m11 = window[10];
    assign o_m12 = window[11];
    assign o_m13 = window[12];
    assign o_m14 = window[13];
    assign o_m15 = window[14];
    assign o_m16 = window[15];
    assign o_m17 = window[16];
    assign o_m18 = window[17];
    assign o_m19 = window[18];
    assign o_m20 = window[19];
    assign o_m21 = window[20];
    assign o_m22 = window[21];
    assign o_m23 = window[22];
    assign o_m24 = window[23];
    assign o_m25 = window[24];

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_LOAD;
            pix_cnt          <= '0;
            res_cnt          <= '0;
            wait_cnt         <= '0;
            o_pix_ready      <= 1'b0;
            o_gradient_start <= 1'b0;
            o_res_valid      <= 1'b0;
            o_res_data       <= '0;
            o_res_last       <= 1'b0;
            o_timeout        <= 1'b0;
            for (int i = 0; i < 25; i++) window[i] <= '0;
            for (int i = 0; i < 9; i++) sum_buf[i] <= '0;
        end else begin
            o_gradient_start <= 1'b0;
            case (state)
                S_LOAD: begin
                    o_pix_ready <= 1'b1;
                    if (i_pix_valid && o_pix_ready) begin
                        window[pix_cnt] <= i_pix_data;
                        o_timeout       <= 1'b0;
                        if (pix_cnt == 5'd24) begin
                            pix_cnt          <= '0;
                            o_pix_ready      <= 1'b0;
                            o_gradient_start <= 1'b1;
                            state            <= S_START;
                        end else begin
                            pix_cnt <= pix_cnt + 5'd1;
                        end
                    end
                end
                S_START: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A ready arriving on the final timeout cycle still wins.
                    if (i_gradient_ready) begin
                        for (int i = 0; i < 9; i++) sum_buf[i] <= sum_in[i];
                        o_res_valid <= 1'b1;
                        o_res_data  <= sum_in[0];
                        o_res_last  <= 1'b0;
                        res_cnt     <= '0;
                        state       <= S_SEND;
                    end else if (wait_cnt == WAIT_LAST) begin
                        o_timeout   <= 1'b1;
                        o_pix_ready <= 1'b1;
                        state       <= S_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (i_res_ready) begin
                        if (res_cnt == 4'd8) begin
                            res_cnt     <= '0;
                            o_res_valid <= 1'b0;
                            o_res_data  <= '0;
                            o_res_last  <= 1'b0;
                            o_pix_ready <= 1'b1;
                            state       <= S_LOAD;
                        end else begin
                            res_cnt    <= res_cnt + 4'd1;
                            o_res_data <= sum_buf[res_cnt + 4'd1];
                            o_res_last <= (res_cnt == 4'd7);
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_window_controller.sv
// tb/tb_edge_window_controller.sv - directed self-checking bench for edge_window_controller
module tb_edge_window_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_pix_valid = 1'b0;
    logic [7:0] i_pix_data = '0;
    logic       o_pix_ready;
    logic [7:0] o_m1, o_m2, o_m3, o_m4, o_m5, o_m6, o_m7, o_m8, o_m9, o_m10;
    logic [7:0] o_m11, o_m12, o_m13, o_m14, o_m15, o_m16, o_m17, o_m18, o_m19, o_m20;
    logic [7:0] o_m21, o_m22, o_m23, o_m24, o_m25;
    logic       o_gradient_start;
    logic       i_gradient_ready = 1'b0;
    logic [7:0] sums [9];
    logic       o_res_valid;
    logic [7:0] o_res_data;
    logic       o_res_last;
    logic       i_res_ready = 1'b0;
    logic       o_timeout;
    logic [199:0] m_all;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign m_all = {o_m25, o_m24, o_m23, o_m22, o_m21, o_m20, o_m19, o_m18, o_m17, o_m16,
                    o_m15, o_m14, o_m13, o_m12, o_m11, o_m10, o_m9, o_m8, o_m7, o_m6,
                    o_m5, o_m4, o_m3, o_m2, o_m1};

    edge_window_controller #(.TIMEOUT(8), .THRESHOLD(128)) dut (
        .clk(clk), .rst(rst), .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data),
        .o_pix_ready(o_pix_ready),
        .o_m1(o_m1), .o_m2(o_m2), .o_m3(o_m3), .o_m4(o_m4), .o_m5(o_m5),
        .o_m6(o_m6), .o_m7(o_m7), .o_m8(o_m8), .o_m9(o_m9), .o_m10(o_m10),
        .o_m11(o_m11), .o_m12(o_m12), .o_m13(o_m13), .o_m14(o_m14), .o_m15(o_m15),
        .o_m16(o_m16), .o_m17(o_m17), .o_m18(o_m18), .o_m19(o_m19), .o_m20(o_m20),
        .o_m21(o_m21), .o_m22(o_m22), .o_m23(o_m23), .o_m24(o_m24), .o_m25(o_m25),
        .o_gradient_start(o_gradient_start), .i_gradient_ready(i_gradient_ready),
        .i_sum_1(sums[0]), .i_sum_2(sums[1]), .i_sum_3(sums[2]), .i_sum_4(sums[3]),
        .i_sum_5(sums[4]), .i_sum_6(sums[5]), .i_sum_7(sums[6]), .i_sum_8(sums[7]),
        .i_sum_9(sums[8]),
        .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_last(o_res_last),
        .i_res_ready(i_res_ready), .o_timeout(o_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_pix_valid = 1'b0;
        i_gradient_ready = 1'b0;
        i_res_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    function automatic logic [199:0] exp_window(input logic [7:0] base);
        logic [199:0] v;
        for (int i = 0; i < 25; i++) v[i*8 +: 8] = base + 8'(i);
        return v;
    endfunction

    task automatic push_pixel(input logic [7:0] d);
        int b = 0;
        while (o_pix_ready !== 1'b1 && b < 100) begin
            step();
            b++;
        end
        if (b >= 100) begin
            checks++;
            errors++;
            $display("FAIL pix_ready_wait: o_pix_ready=%b, required 1 within 100 cycles", o_pix_ready);
        end
        i_pix_valid = 1'b1;
        i_pix_data  = d;
        step();
        i_pix_valid = 1'b0;
    endtask

    // Returns in the START cycle (start pulse visible).
    task automatic push_window(input logic [7:0] base);
        for (int i = 0; i < 25; i++) push_pixel(base + 8'(i));
    endtask

    task automatic collect(input logic [7:0] exp [9], input bit toggle, input string nm);
        int n = 0;
        int cyc = 0;
        bit held = 0;
        logic [7:0] prev = '0;
        while (n < 9 && cyc < 200) begin
            i_res_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (o_res_valid === 1'b1) begin
                if (held) begin
                    checks++;
                    if (o_res_data !== prev) begin
                        errors++;
                        $display("FAIL %s_hold: data=%h, required %h", nm, o_res_data, prev);
                    end
                end
                if (i_res_ready) begin
                    checks++;
                    if (o_res_data !== exp[n] || o_res_last !== (n == 8)) begin
                        errors++;
                        $display("FAIL %s_beat%0d: data=%h last=%b, required data=%h last=%b",
                                 nm, n, o_res_data, o_res_last, exp[n], (n == 8));
                    end
                    n++;
                    held = 0;
                end else begin
                    held = 1;
                    prev = o_res_data;
                end
            end
            step();
            cyc++;
        end
        i_res_ready = 1'b0;
        checks++;
        if (n != 9 || o_res_valid !== 1'b0 || o_pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_end: beats=%0d valid=%b pix_ready=%b, required 9 0 1",
                     nm, n, o_res_valid, o_pix_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({o_pix_ready, o_gradient_start, o_res_valid, o_res_last, o_timeout} !== 5'b0 ||
            o_res_data !== 8'h00 || m_all !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b start=%b valid=%b data=%h timeout=%b, required all 0",
                     o_pix_ready, o_gradient_start, o_res_valid, o_res_data, o_timeout);
        end
        rst = 1'b0;
        step();
        checks++;
        if (o_pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: o_pix_ready=%b, required 1", o_pix_ready);
        end
    endtask

    task automatic test_basic(input bit toggle, input string nm);
        logic [7:0] exp [9];
        for (int i = 0; i < 9; i++) begin
            sums[i] = 8'(10 + i);
            exp[i]  = 8'(10 + i);
        end
        push_window(8'd1);
        checks++;
        if (o_gradient_start !== 1'b1 || o_pix_ready !== 1'b0 || m_all !== exp_window(8'd1)) begin
            errors++;
            $display("FAIL %s_start: start=%b pix_ready=%b window_ok=%b, required 1 0 1",
                     nm, o_gradient_start, o_pix_ready, m_all === exp_window(8'd1));
        end
        step();
        checks++;
        if (o_gradient_start !== 1'b0) begin
            errors++;
            $display("FAIL %s_single_pulse: start=%b, required 0", nm, o_gradient_start);
        end
        step();
        step();
        i_gradient_ready = 1'b1;
        step();
        i_gradient_ready = 1'b0;
        checks++;
        if (o_res_valid !== 1'b1 || o_res_data !== 8'd10 || o_res_last !== 1'b0) begin
            errors++;
            $display("FAIL %s_first_beat: valid=%b data=%h last=%b, required 1 0a 0",
                     nm, o_res_valid, o_res_data, o_res_last);
        end
        collect(exp, toggle, nm);
    endtask

    task automatic test_timeout();
        do_reset();
        push_window(8'd1);
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: o_timeout=%b, required 0", o_timeout);
        end
        step();
        checks++;
        if (o_timeout !== 1'b1 || o_pix_ready !== 1'b1 || o_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_set: timeout=%b pix_ready=%b valid=%b, required 1 1 0",
                     o_timeout, o_pix_ready, o_res_valid);
        end
        push_pixel(8'h33);
        checks++;
        if (o_timeout !== 1'b0 || o_m1 !== 8'h33) begin
            errors++;
            $display("FAIL timeout_clear: timeout=%b m1=%h, required 0 33", o_timeout, o_m1);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [9];
        do_reset();
        for (int i = 0; i < 9; i++) sums[i] = 8'(20 + i);
        push_window(8'd40);
        step();
        i_gradient_ready = 1'b1;
        step();
        i_gradient_ready = 1'b0;
        i_res_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        i_res_ready = 1'b0;
        checks++;
        if (o_res_valid !== 1'b1 || o_res_data !== 8'd24) begin
            errors++;
            $display("FAIL midrst_fifth: valid=%b data=%h, required 1 18", o_res_valid, o_res_data);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({o_pix_ready, o_gradient_start, o_res_valid, o_res_last, o_timeout} !== 5'b0 ||
            o_res_data !== 8'h00 || m_all !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: ready=%b valid=%b data=%h, required all 0",
                     o_pix_ready, o_res_valid, o_res_data);
        end
        rst = 1'b0;
        step();
        checks++;
        if (o_pix_ready !== 1'b1 || o_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: pix_ready=%b valid=%b, required 1 0", o_pix_ready, o_res_valid);
        end
        for (int i = 0; i < 9; i++) begin
            sums[i] = 8'(50 + i);
            exp[i]  = 8'(50 + i);
        end
        push_window(8'd100);
        checks++;
        if (m_all !== exp_window(8'd100)) begin
            errors++;
            $display("FAIL midrst_window: m1=%h m25=%h, required 64 7c", o_m1, o_m25);
        end
        i_gradient_ready = 1'b1;
        step();
        step();
        i_gradient_ready = 1'b0;
        collect(exp, 1'b0, "midrst");
    endtask

    task automatic test_no_overlap();
        logic [7:0] exp [9];
        do_reset();
        for (int i = 0; i < 9; i++) begin
            sums[i] = 8'(200 + i);
            exp[i]  = 8'(200 + i);
        end
        push_window(8'd7);
        i_pix_valid = 1'b1;
        i_pix_data  = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_pix_ready !== 1'b0 || m_all !== exp_window(8'd7)) begin
                errors++;
                $display("FAIL overlap_c%0d: pix_ready=%b m1=%h, required 0 07", k, o_pix_ready, o_m1);
            end
            if (k == 2) i_gradient_ready = 1'b1;
            step();
        end
        i_gradient_ready = 1'b0;
        collect(exp, 1'b0, "overlap");
        checks++;
        if (m_all !== exp_window(8'd7)) begin
            errors++;
            $display("FAIL overlap_window: m1=%h m25=%h, required 07 1f", o_m1, o_m25);
        end
        i_pix_valid = 1'b0;
    endtask

    task automatic test_threshold();
        logic [7:0] in_v [9];
        logic [7:0] exp [9];
        in_v = '{8'd0, 8'd127, 8'd128, 8'd255, 8'd1, 8'd200, 8'd129, 8'd126, 8'd64};
`ifdef EDGE_THRESH_EN
        exp = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
`else
        exp = in_v;
`endif
        do_reset();
        for (int i = 0; i < 9; i++) sums[i] = in_v[i];
        push_window(8'd3);
        step();
        i_gradient_ready = 1'b1;
        step();
        i_gradient_ready = 1'b0;
        for (int i = 0; i < 9; i++) sums[i] = 8'h5A;
        collect(exp, 1'b0, "thresh");
    endtask

    initial begin
        for (int i = 0; i < 9; i++) sums[i] = '0;
        test_reset();
        test_basic(1'b0, "basic");
        test_basic(1'b1, "toggle");
        test_timeout();
        test_reset_mid();
        test_no_overlap();
        test_threshold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
